ahb_ram_bridge: RTL and testbench

- AHB-Lite slave front end that sits directly upstream of the byte-lane data RAM.
- Converts pipelined AHB address/data phases into the RAM's size/write_enable/address/write_data controls.
- Re-aligns the RAM's low-justified read data onto AHB byte lanes.
- Inserts a wait state when a read collides with a preceding write, and returns a two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_ram_bridge.sv | 67 ++++++
 tb/tb_ahb_ram_bridge.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ahb_ram_bridge.sv
// ahb_ram_bridge: AHB-Lite slave front end driving a byte-lane RAM with lane re-alignment, RAW wait state and ERROR response
module ahb_ram_bridge #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [1:0]        ram_size,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic acc, illegal, use_q;
  logic [31:0] lanes;
  logic unused;
  assign unused = ^{haddr[31:RAM_AW], htrans[0]};
  assign acc = hsel & htrans[1] & hready;
  assign illegal = (hsize > 3'd2) | (hsize == 3'd1 & haddr[0]) | (hsize == 3'd2 & haddr[1:0] != 2'b00);
  always_comb begin
    addr_d = acc ? haddr[RAM_AW-1:0] : addr_q;
    size_d = acc ? hsize[1:0] : size_q;
    state_d = state_q == RD_WAIT ? RD :
              state_q == ERR1    ? ERR2 :
              !acc               ? IDLE :
              illegal            ? ERR1 :
              hwrite             ? WR :
              state_q == WR      ? RD_WAIT : RD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end
  // outside WR/RD_WAIT the RAM sees the live address phase, so reads need no wait state
  always_comb begin
    use_q     = state_q == WR || state_q == RD_WAIT;
    ram_we    = state_q == WR;
    ram_addr  = use_q ? addr_q : haddr[RAM_AW-1:0];
    ram_size  = use_q ? size_q : (hsize[1:0] == 2'b11 ? 2'b10 : hsize[1:0]);
    ram_wdata = hwdata;
    hreadyout = !(state_q == RD_WAIT || state_q == ERR1);
    hresp     = state_q == ERR1 || state_q == ERR2;
    lanes     = size_q == 2'b00 ? ram_rdata << {addr_q[1:0], 3'b000} :
                size_q == 2'b01 ? ram_rdata << {addr_q[1], 4'b0000} : ram_rdata;
    hrdata    = state_q == RD ? lanes : '0;
  end
endmodule

// File: tb/tb_ahb_ram_bridge.sv
// tb_ahb_ram_bridge: directed cycle vectors against a byte-lane RAM model, plus an async-reset-during-write sequence
module tb_ahb_ram_bridge;
  logic clk = 0, rst = 0;
  logic hsel, hwrite, hready, hreadyout, hresp, ram_we;
  logic [31:0] haddr, hwdata, hrdata, ram_wdata, ram_rdata;
  logic [1:0] htrans, ram_size;
  logic [2:0] hsize;
  logic [9:0] ram_addr;
  int checks = 0, failures = 0;
  logic [7:0] mem [0:1023];

  ahb_ram_bridge #(.RAM_AW(10)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .ram_size(ram_size), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (ram_we)
      for (int k = 0; k < 4; k++)
        if (ram_size == 2'b10 || (ram_size == 2'b01 && k / 2 == int'(ram_addr[1])) || (ram_size == 2'b00 && k == int'(ram_addr[1:0])))
          mem[{ram_addr[9:2], 2'(k)}] <= ram_wdata[8*k +: 8];
    case (ram_size)
      2'b00:   ram_rdata <= {24'h0, mem[ram_addr]};
      2'b01:   ram_rdata <= {16'h0, mem[{ram_addr[9:1], 1'b1}], mem[{ram_addr[9:1], 1'b0}]};
      default: ram_rdata <= {mem[{ram_addr[9:2], 2'd3}], mem[{ram_addr[9:2], 2'd2}], mem[{ram_addr[9:2], 2'd1}], mem[{ram_addr[9:2], 2'd0}]};
    endcase
  end

  typedef struct {
    logic hsel; logic [31:0] haddr; logic [1:0] htrans; logic hwrite; logic [2:0] hsize;
    logic [31:0] hwdata; logic hready;
    logic e_rdy; logic e_resp; logic [31:0] e_rdata; logic e_we; logic [9:0] e_addr; logic [1:0] e_size;
  } vec_t;

  function automatic vec_t mk(logic s, logic [31:0] a, logic [1:0] t, logic w, logic [2:0] z, logic [31:0] d, logic r,
                              logic er, logic ep, logic [31:0] ed, logic ew, logic [9:0] ea, logic [1:0] ez);
    vec_t v;
    v.hsel = s; v.haddr = a; v.htrans = t; v.hwrite = w; v.hsize = z; v.hwdata = d; v.hready = r;
    v.e_rdy = er; v.e_resp = ep; v.e_rdata = ed; v.e_we = ew; v.e_addr = ea; v.e_size = ez;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(logic s, logic [31:0] a, logic [1:0] t, logic w, logic [2:0] z, logic [31:0] d, logic r);
    hsel = s; haddr = a; htrans = t; hwrite = w; hsize = z; hwdata = d; hready = r;
  endtask

  vec_t tbl [21];

  initial begin
    tbl[0]  = mk(1, 'h010, 2, 1, 2, 0, 1,            1, 0, 0, 0, 'h010, 2);
    tbl[1]  = mk(1, 'h010, 2, 0, 2, 'h11223344, 1,   1, 0, 0, 1, 'h010, 2);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 'h010, 2);
    tbl[3]  = mk(1, 'h012, 2, 1, 0, 0, 1,            1, 0, 'h11223344, 0, 'h012, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 'h00AB0000, 1,       1, 0, 0, 1, 'h012, 0);
    tbl[5]  = mk(1, 'h012, 2, 0, 0, 0, 1,            1, 0, 0, 0, 'h012, 0);
    tbl[6]  = mk(1, 'h014, 2, 1, 2, 0, 1,            1, 0, 'h00AB0000, 0, 'h014, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 'hDEADBEEF, 1,       1, 0, 0, 1, 'h014, 2);
    tbl[8]  = mk(1, 'h016, 2, 0, 1, 0, 1,            1, 0, 0, 0, 'h016, 1);
    tbl[9]  = mk(1, 'h002, 2, 0, 2, 0, 1,            1, 0, 'hDEAD0000, 0, 'h002, 2);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,                0, 1, 0, 0, 0, 0);
    tbl[11] = mk(1, 'h020, 2, 1, 2, 0, 1,            1, 1, 0, 0, 'h020, 2);
    tbl[12] = mk(1, 'h024, 2, 1, 2, 1, 1,            1, 0, 0, 1, 'h020, 2);
    tbl[13] = mk(1, 'h020, 2, 0, 2, 2, 1,            1, 0, 0, 1, 'h024, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 'h020, 2);
    tbl[15] = mk(1, 'h000, 2, 0, 2, 0, 1,            1, 0, 1, 0, 0, 2);
    tbl[16] = mk(1, 'h000, 2, 1, 3, 0, 1,            1, 0, 0, 0, 0, 2);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,                0, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 'h040, 2, 1, 2, 0, 1,            1, 1, 0, 0, 'h040, 2);
    tbl[19] = mk(1, 'h044, 1, 1, 2, 'hFFFFFFFF, 1,   1, 0, 0, 0, 'h044, 2);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1,                1, 0, 0, 0, 0, 0);

    drive(0, 'h123, 0, 0, 1, 'h5A5A5A5A, 1);
    #3;
    chk("rst_hreadyout", 32'(hreadyout), 1);
    chk("rst_hresp", 32'(hresp), 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 'h123);
    chk("rst_ram_size", 32'(ram_size), 1);
    chk("rst_ram_wdata", ram_wdata, 'h5A5A5A5A);
    repeat (2) @(negedge clk);
    rst = 1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].hsel, tbl[i].haddr, tbl[i].htrans, tbl[i].hwrite, tbl[i].hsize, tbl[i].hwdata, tbl[i].hready);
      #4;
      chk($sformatf("v%0d_hreadyout", i), 32'(hreadyout), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_hresp", i), 32'(hresp), 32'(tbl[i].e_resp));
      chk($sformatf("v%0d_hrdata", i), hrdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_ram_size", i), 32'(ram_size), 32'(tbl[i].e_size));
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, tbl[i].hwdata);
      @(negedge clk);
    end

    // seed 0x030, then reset in the middle of a second write to it
    drive(1, 'h030, 2, 1, 2, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 'h55667788, 1);
    #4 chk("seed_we", 32'(ram_we), 1);
    @(negedge clk);
    drive(1, 'h030, 2, 1, 2, 0, 1);
    @(negedge clk);
    drive(0, 'h3FC, 0, 0, 0, 'h99999999, 1);
    #1 chk("wr_before_rst_we", 32'(ram_we), 1);
    #1 rst = 0;
    #1;
    chk("async_rst_we", 32'(ram_we), 0);
    chk("async_rst_hreadyout", 32'(hreadyout), 1);
    chk("async_rst_hresp", 32'(hresp), 0);
    chk("async_rst_ram_addr", 32'(ram_addr), 'h3FC);
    @(negedge clk);
    chk("rst_hold_we", 32'(ram_we), 0);
    chk("rst_hold_hreadyout", 32'(hreadyout), 1);
    rst = 1;
    drive(1, 'h030, 2, 0, 2, 0, 1);
    #4 chk("post_rst_rd_addr", 32'(ram_addr), 'h030);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #4;
    chk("post_rst_rd_hreadyout", 32'(hreadyout), 1);
    chk("post_rst_rd_hrdata", hrdata, 'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
